acc_paren_stack: RTL and testbench
==================================

Name: acc_paren_stack

Overview:
- Accumulator register plus operand/operator stack for IL parenthesised expressions (e.g. "AND(" ... ")").
- Sits directly downstream of the accumulator input mux. It registers the mux output as the current accumulator (CR).
- On "op(" it saves CR and the pending operator. On ")" it returns both to the ALU so the ALU can combine the saved value with the inner result.

Parameters:
- DATA_W, 8, accumulator and stack data width.
- OP_W, 4, width of the saved pending-operator code.
- DEPTH, 4, maximum nesting depth (number of stack entries, ≥2).
- PTR_W, 3, width of depth count; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- acc_in  in  DATA_W  next accumulator value from accumulator mux
- acc_we  in  1  load acc_in into accumulator this cycle
- push  in  1  open parenthesis: save current accumulator and op_in
- op_in  in  OP_W  pending operator code saved with push
- pop  in  1  close parenthesis: retrieve top entry
- err_clr  in  1  clear sticky error flag
- acc_out  out  DATA_W  registered accumulator value
- acc_zero  out  1  combinational, acc_out == 0
- pop_data  out  DATA_W  accumulator value saved by the matching push
- pop_op  out  OP_W  operator code saved by the matching push
- pop_valid  out  1  one-cycle strobe; pop_data/pop_op valid
- depth  out  PTR_W  number of occupied entries
- stack_full  out  1  depth == DEPTH
- stack_empty  out  1  depth == 0
- stack_err  out  1  sticky overflow/underflow/conflict flag

Behaviour:
- Reset (reset==0 at a rising edge) has priority over all other inputs.
  - acc_out=0, pop_data=0, pop_op=0, pop_valid=0, depth=0, stack_err=0.
  - Stack contents are don't-care after reset.
  - A reset mid-expression discards all nesting.
- Accumulator:
  - acc_we=1 → acc_out <= acc_in at the edge (1-cycle latency).
  - Otherwise acc_out holds.
- Push (push=1, pop=0):
  - If not full: entry[depth] <= {op_in, acc_out}, then depth+1.
  - The saved value is always the pre-edge acc_out. With acc_we also asserted, the old value is pushed and acc_in is loaded in the same edge (supports "AND( LD x" fused).
  - If full: stack and depth unchanged, stack_err <= 1. acc_we is still honoured.
- Pop (pop=1, push=0):
  - If not empty: {pop_op, pop_data} <= entry[depth-1], depth-1, pop_valid <= 1 for exactly one cycle.
  - If empty: depth unchanged, pop_valid stays 0, pop_data/pop_op hold, stack_err <= 1.
  - acc_we on the same cycle is independent and honoured.
- pop_valid is 0 in every cycle not immediately following a successful pop.
- pop_data/pop_op hold their last value until the next successful pop.
- push and pop both 1: treated as a sequencing error.
  - No stack change, pop_valid=0, stack_err <= 1.
  - acc_we still honoured.
- stack_err is sticky.
  - Cleared only by reset, or by err_clr=1 when no new error occurs that cycle.
  - A new error in the same cycle as err_clr wins; the flag stays 1.
- stack_full, stack_empty and acc_zero are combinational decodes of registered state.
- depth never exceeds DEPTH and never wraps below 0.
- No arithmetic beyond the depth increment/decrement. Data is passed through unmodified; DATA_W bits are stored exactly.

Test Plan:
- Reset then acc_in=8'h3C, acc_we=1 one cycle → acc_out=8'h3C next cycle, acc_zero=0, depth=0, stack_empty=1.
- acc_out=8'h3C, push=1, op_in=4'h2, acc_we=1, acc_in=8'h05 → next cycle acc_out=8'h05, depth=1. Then pop → pop_valid=1 for one cycle with pop_data=8'h3C, pop_op=4'h2, depth=0.
- Four pushes of values 8'h11, 8'h22, 8'h33, 8'h44 (DEPTH=4) → stack_full=1. Fifth push → depth stays 4, stack_err=1. Four pops return 44, 33, 22, 11 in LIFO order.
- Pop on empty stack → pop_valid=0, depth=0, stack_err=1. err_clr=1 next cycle → stack_err=0.
- push=1 and pop=1 together at depth=2 → depth=2, pop_valid=0, stack_err=1. A following pop still returns the correct top entry.
- depth=3 with acc_out=8'hA5, assert reset=0 for one edge → acc_out=0, depth=0, stack_err=0, pop_valid=0. A following pop flags underflow.

Source files
------------

// File: rtl/acc_paren_stack_if.sv
// -----------------------------------------------------------------------------
// acc_paren_stack_if
//   Groups the signals between the instruction-list sequencer/ALU and the
//   accumulator + parenthesis stack.
//
//   Sequencer -> stack (driven by master):
//     acc_in    next accumulator value from the accumulator mux
//     acc_we    load acc_in into the accumulator this cycle
//     push      open parenthesis: save accumulator and op_in
//     op_in     pending operator code saved with push
//     pop       close parenthesis: retrieve the top entry
//     err_clr   clear the sticky error flag
//   Stack -> sequencer/ALU (driven by slave):
//     acc_out, acc_zero, pop_data, pop_op, pop_valid,
//     depth, stack_full, stack_empty, stack_err
// -----------------------------------------------------------------------------
interface acc_paren_stack_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int PTR_W  = 3
);
    logic [DATA_W-1:0] acc_in;
    logic              acc_we;
    logic              push;
    logic [OP_W-1:0]   op_in;
    logic              pop;
    logic              err_clr;

    logic [DATA_W-1:0] acc_out;
    logic              acc_zero;
    logic [DATA_W-1:0] pop_data;
    logic [OP_W-1:0]   pop_op;
    logic              pop_valid;
    logic [PTR_W-1:0]  depth;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output acc_in, acc_we, push, op_in, pop, err_clr,
        input  acc_out, acc_zero, pop_data, pop_op, pop_valid,
               depth, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  acc_in, acc_we, push, op_in, pop, err_clr,
        output acc_out, acc_zero, pop_data, pop_op, pop_valid,
               depth, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/acc_paren_stack.sv
// -----------------------------------------------------------------------------
// acc_paren_stack
//   Current-result accumulator (CR) plus a LIFO of {operator, CR} pairs used
//   to evaluate parenthesised IL expressions such as "AND( ... )".
//   "op(" pushes the pre-edge CR together with the pending operator; ")" pops
//   them back so the ALU can combine the saved value with the inner result.
//
//   Ports:
//     clk    rising-edge clock for all state
//     reset  synchronous, active-low; clears accumulator, pop outputs,
//            depth and the error flag (stack storage is left as is)
//     bus    acc_paren_stack_if.slave, see the interface for signal list
// -----------------------------------------------------------------------------
module acc_paren_stack #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 3
) (
    input logic               clk,
    input logic               reset,
    acc_paren_stack_if.slave  bus
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            stackMem [DEPTH];
    logic [DATA_W-1:0] accQ;
    logic [DATA_W-1:0] popDataQ;
    logic [OP_W-1:0]   popOpQ;
    logic              popValidQ;
    logic [PTR_W-1:0]  depthQ;
    logic              errQ;

    logic              isFull;
    logic              isEmpty;
    logic              pushOk;
    logic              popOk;
    logic              errNow;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  rdIdx;
    entry_t            topEntry;

    assign isFull   = (depthQ == DEPTH_P);
    assign isEmpty  = (depthQ == '0);

    // The write slot is the first free entry; the read slot is the top entry.
    // Both are only used when depth is in range, so truncation is safe.
    assign wrIdx    = IDX_W'(depthQ);
    assign rdIdx    = IDX_W'(depthQ - PTR_W'(1));
    assign topEntry = stackMem[rdIdx];

    // Decode the stack command. push and pop together is a sequencing error
    // and must not move the stack in either direction.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        pushOk = 1'b0;
        popOk  = 1'b0;
        errNow = 1'b0;
        if (bus.push && bus.pop) begin
            errNow = 1'b1;
        end else if (bus.push) begin
            if (isFull) errNow = 1'b1;
            else        pushOk = 1'b1;
        end else if (bus.pop) begin
            if (isEmpty) errNow = 1'b1;
            else         popOk  = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; after reset depth is 0, so old
    // contents are unreachable and clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (reset && pushOk) begin
            // Always the pre-edge accumulator, even when acc_we loads a new
            // value on the same edge ("AND( LD x" fused).
            stackMem[wrIdx] <= {bus.op_in, accQ};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            accQ      <= '0;
            popDataQ  <= '0;
            popOpQ    <= '0;
            popValidQ <= 1'b0;
            depthQ    <= '0;
            errQ      <= 1'b0;
        end else begin
            if (bus.acc_we) accQ <= bus.acc_in;

            popValidQ <= popOk;
            if (pushOk) begin
                depthQ <= depthQ + PTR_W'(1);
            end else if (popOk) begin
                depthQ   <= depthQ - PTR_W'(1);
                popDataQ <= topEntry.data;
                popOpQ   <= topEntry.op;
            end

            // A fresh error beats a clear request in the same cycle.
            if (errNow)           errQ <= 1'b1;
            else if (bus.err_clr) errQ <= 1'b0;
        end
    end

    assign bus.acc_out     = accQ;
    assign bus.acc_zero    = (accQ == '0);
    assign bus.pop_data    = popDataQ;
    assign bus.pop_op      = popOpQ;
    assign bus.pop_valid   = popValidQ;
    assign bus.depth       = depthQ;
    assign bus.stack_full  = isFull;
    assign bus.stack_empty = isEmpty;
    assign bus.stack_err   = errQ;

endmodule

// File: tb/tb_acc_paren_stack.sv
// -----------------------------------------------------------------------------
// tb_acc_paren_stack
//   Directed scenarios plus a randomized run for acc_paren_stack. Expected
//   values come from literal constants and from a queue-based model of the
//   accumulator/parenthesis stack.
// -----------------------------------------------------------------------------
module tb_acc_paren_stack;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 3;

    logic clk = 1'b0;
    logic reset;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    acc_paren_stack_if #(.DATA_W(DATA_W), .OP_W(OP_W), .PTR_W(PTR_W)) bus ();

    acc_paren_stack #(
        .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0]      mAcc;
    logic [OP_W+DATA_W-1:0] mStack [$];
    logic                   mErr;
    logic                   mPv;
    logic [DATA_W-1:0]      mPd;
    logic [OP_W-1:0]        mPo;

    // Drive one cycle of inputs, advance the model, wait for the edge and
    // settle 1 time unit past it so outputs can be sampled.
    task automatic tick(input logic rstN, input logic [DATA_W-1:0] accIn,
                        input logic we, input logic ps, input logic [OP_W-1:0] op,
                        input logic pp, input logic clr);
        logic                   err;
        logic [OP_W+DATA_W-1:0] e;
        reset       = rstN;
        bus.acc_in  = accIn;
        bus.acc_we  = we;
        bus.push    = ps;
        bus.op_in   = op;
        bus.pop     = pp;
        bus.err_clr = clr;
        if (!rstN) begin
            mAcc = '0; mStack.delete(); mErr = 1'b0; mPv = 1'b0; mPd = '0; mPo = '0;
        end else begin
            err = 1'b0;
            mPv = 1'b0;
            if (ps && pp) err = 1'b1;
            else if (ps) begin
                if (mStack.size() == DEPTH) err = 1'b1;
                else mStack.push_back({op, mAcc});
            end else if (pp) begin
                if (mStack.size() == 0) err = 1'b1;
                else begin
                    e   = mStack.pop_back();
                    mPo = e[OP_W+DATA_W-1:DATA_W];
                    mPd = e[DATA_W-1:0];
                    mPv = 1'b1;
                end
            end
            if (we) mAcc = accIn;
            if (err) mErr = 1'b1;
            else if (clr) mErr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [27:0] got;
        doReset();
        got = {bus.acc_out, bus.pop_data, bus.pop_op, bus.pop_valid, bus.depth,
               bus.stack_err, bus.stack_empty, bus.stack_full, bus.acc_zero};
        nCompared++;
        if (got !== {8'h00, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("FAIL reset_state: got %h want %h", got,
                     {8'h00, 8'h00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic test_acc_load();
        tick(1'b1, 8'h3C, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        nCompared++;
        if ({bus.acc_out, bus.acc_zero, bus.depth, bus.stack_empty} !== {8'h3C, 1'b0, 3'd0, 1'b1}) begin
            nMismatched++;
            $display("FAIL acc_load: acc=%h zero=%b depth=%0d empty=%b want acc=3c zero=0 depth=0 empty=1",
                     bus.acc_out, bus.acc_zero, bus.depth, bus.stack_empty);
        end
        idle();
        nCompared++;
        if (bus.acc_out !== 8'h3C) begin
            nMismatched++;
            $display("FAIL acc_hold: acc=%h want 3c", bus.acc_out);
        end
    endtask

    task automatic test_fused_push_pop();
        tick(1'b1, 8'h05, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        nCompared++;
        if ({bus.acc_out, bus.depth, bus.pop_valid} !== {8'h05, 3'd1, 1'b0}) begin
            nMismatched++;
            $display("FAIL fused_push: acc=%h depth=%0d pv=%b want acc=05 depth=1 pv=0",
                     bus.acc_out, bus.depth, bus.pop_valid);
        end
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        nCompared++;
        if ({bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth} !== {1'b1, 8'h3C, 4'h2, 3'd0}) begin
            nMismatched++;
            $display("FAIL fused_pop: pv=%b data=%h op=%h depth=%0d want pv=1 data=3c op=2 depth=0",
                     bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth);
        end
        idle();
        nCompared++;
        if ({bus.pop_valid, bus.pop_data, bus.pop_op} !== {1'b0, 8'h3C, 4'h2}) begin
            nMismatched++;
            $display("FAIL pop_strobe_hold: pv=%b data=%h op=%h want pv=0 data=3c op=2",
                     bus.pop_valid, bus.pop_data, bus.pop_op);
        end
    endtask

    task automatic test_fill_overflow();
        logic [DATA_W-1:0] v;
        doReset();
        tick(1'b1, 8'h11, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        // Each push saves the previous value while loading the next one.
        for (int i = 1; i < 4; i++) begin
            v = DATA_W'(8'h11 * (i + 1));
            tick(1'b1, v, 1'b1, 1'b1, OP_W'(i), 1'b0, 1'b0);
        end
        tick(1'b1, '0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        nCompared++;
        if ({bus.stack_full, bus.depth, bus.stack_err} !== {1'b1, 3'd4, 1'b0}) begin
            nMismatched++;
            $display("FAIL fill: full=%b depth=%0d err=%b want full=1 depth=4 err=0",
                     bus.stack_full, bus.depth, bus.stack_err);
        end
        tick(1'b1, 8'h99, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
        nCompared++;
        if ({bus.depth, bus.stack_err, bus.stack_full, bus.acc_out} !== {3'd4, 1'b1, 1'b1, 8'h99}) begin
            nMismatched++;
            $display("FAIL overflow: depth=%0d err=%b full=%b acc=%h want depth=4 err=1 full=1 acc=99",
                     bus.depth, bus.stack_err, bus.stack_full, bus.acc_out);
        end
        for (int i = 4; i >= 1; i--) begin
            tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
            v = DATA_W'(8'h11 * i);
            nCompared++;
            if ({bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth} !==
                {1'b1, v, OP_W'(i), PTR_W'(i - 1)}) begin
                nMismatched++;
                $display("FAIL lifo_pop%0d: pv=%b data=%h op=%h depth=%0d want pv=1 data=%h op=%h depth=%0d",
                         i, bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth, v, OP_W'(i), i - 1);
            end
        end
        nCompared++;
        if (bus.stack_empty !== 1'b1) begin
            nMismatched++;
            $display("FAIL drained_empty: empty=%b want 1", bus.stack_empty);
        end
    endtask

    task automatic test_underflow_clear();
        doReset();
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        nCompared++;
        if ({bus.pop_valid, bus.depth, bus.stack_err, bus.pop_data} !== {1'b0, 3'd0, 1'b1, 8'h00}) begin
            nMismatched++;
            $display("FAIL underflow: pv=%b depth=%0d err=%b data=%h want pv=0 depth=0 err=1 data=00",
                     bus.pop_valid, bus.depth, bus.stack_err, bus.pop_data);
        end
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        nCompared++;
        if (bus.stack_err !== 1'b0) begin
            nMismatched++;
            $display("FAIL err_clr: err=%b want 0", bus.stack_err);
        end
        // A new error in the same cycle as err_clr keeps the flag set.
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        nCompared++;
        if (bus.stack_err !== 1'b1) begin
            nMismatched++;
            $display("FAIL err_clr_vs_new: err=%b want 1", bus.stack_err);
        end
    endtask

    task automatic test_conflict();
        doReset();
        tick(1'b1, 8'hAA, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 8'hBB, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
        tick(1'b1, 8'hCC, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
        tick(1'b1, 8'hDD, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        nCompared++;
        if ({bus.depth, bus.pop_valid, bus.stack_err, bus.acc_out} !== {3'd2, 1'b0, 1'b1, 8'hDD}) begin
            nMismatched++;
            $display("FAIL conflict: depth=%0d pv=%b err=%b acc=%h want depth=2 pv=0 err=1 acc=dd",
                     bus.depth, bus.pop_valid, bus.stack_err, bus.acc_out);
        end
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        nCompared++;
        if ({bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth} !== {1'b1, 8'hBB, 4'h5, 3'd1}) begin
            nMismatched++;
            $display("FAIL pop_after_conflict: pv=%b data=%h op=%h depth=%0d want pv=1 data=bb op=5 depth=1",
                     bus.pop_valid, bus.pop_data, bus.pop_op, bus.depth);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        tick(1'b1, 8'h01, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, '0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        tick(1'b1, '0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        tick(1'b1, 8'hA5, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0); // leave pop_valid/pop_data non-zero
        tick(1'b1, '0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        nCompared++;
        if ({bus.depth, bus.acc_out} !== {3'd3, 8'hA5}) begin
            nMismatched++;
            $display("FAIL mid_setup: depth=%0d acc=%h want depth=3 acc=a5", bus.depth, bus.acc_out);
        end
        tick(1'b0, 8'h77, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
        nCompared++;
        if ({bus.acc_out, bus.depth, bus.stack_err, bus.pop_valid, bus.pop_data} !==
            {8'h00, 3'd0, 1'b0, 1'b0, 8'h00}) begin
            nMismatched++;
            $display("FAIL mid_reset: acc=%h depth=%0d err=%b pv=%b data=%h want all zero",
                     bus.acc_out, bus.depth, bus.stack_err, bus.pop_valid, bus.pop_data);
        end
        tick(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        nCompared++;
        if ({bus.pop_valid, bus.stack_err, bus.depth} !== {1'b0, 1'b1, 3'd0}) begin
            nMismatched++;
            $display("FAIL post_reset_underflow: pv=%b err=%b depth=%0d want pv=0 err=1 depth=0",
                     bus.pop_valid, bus.stack_err, bus.depth);
        end
    endtask

    task automatic test_random();
        logic [27:0] got;
        logic [27:0] exp;
        logic        rstN;
        logic [DATA_W-1:0] accIn;
        doReset();
        for (int n = 0; n < 600; n++) begin
            rstN  = ($urandom_range(0, 99) >= 2);
            accIn = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
            tick(rstN, accIn, ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 35),
                 OP_W'($urandom), ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 10));
            got = {bus.acc_out, bus.pop_data, bus.pop_op, bus.pop_valid, bus.depth,
                   bus.stack_err, bus.stack_empty, bus.stack_full, bus.acc_zero};
            exp = {mAcc, mPd, mPo, mPv, PTR_W'(mStack.size()), mErr,
                   (mStack.size() == 0), (mStack.size() == DEPTH), (mAcc == '0)};
            nCompared++;
            if (got !== exp) begin
                nMismatched++;
                $display("FAIL random[%0d]: got %h want %h", n, got, exp);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.acc_in  = '0;
        bus.acc_we  = 1'b0;
        bus.push    = 1'b0;
        bus.op_in   = '0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
        #2;
        test_reset();
        test_acc_load();
        test_fused_push_pop();
        test_fill_overflow();
        test_underflow_clear();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
